// File: rtl/snake_collision.sv
// rtl/snake_collision.sv - serial wall/tail collision checker for the snake head position bus
// A new head position is snapshotted, wall-checked, then compared against one tail segment per clock.
module snake_collision #(
   parameter int SEGMENTS   = 15,
   parameter int GRID_W     = 64,
   parameter int GRID_H     = 48,
   parameter int HEAD_RST_X = 32,
   parameter int HEAD_RST_Y = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              head_x,
   input  logic [5:0]              head_y,
   input  logic [7*SEGMENTS-1:0]   tail_x,
   input  logic [6*SEGMENTS-1:0]   tail_y,
   input  logic [3:0]              length,
   input  logic                    enable,
   input  logic                    clear,
   output logic                    busy,
   output logic                    collision,
   output logic                    game_over
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALL   = 2'd1,
      SCAN   = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [3:0]  SEG_C    = 4'(SEGMENTS);
   localparam logic [6:0]  GRID_W_C = 7'(GRID_W);
   localparam logic [5:0]  GRID_H_C = 6'(GRID_H);
   localparam logic [12:0] HEAD_RST = {7'(HEAD_RST_X), 6'(HEAD_RST_Y)};

   state_t                  state_q, state_d;
   logic [12:0]             head_prev_q, head_prev_d;
   logic [3:0]              idx_q, idx_d;
   logic                    hit_q, hit_d;
   logic                    game_over_q, game_over_d;
   logic [6:0]              snap_hx_q;
   logic [5:0]              snap_hy_q;
   logic [7*SEGMENTS-1:0]   snap_tx_q;
   logic [6*SEGMENTS-1:0]   snap_ty_q;
   logic [3:0]              snap_len_q;

   logic                    start;
   logic [3:0]              len_clamped;
   logic [6:0]              seg_x;
   logic [5:0]              seg_y;

   assign len_clamped = (length > SEG_C) ? SEG_C : length;
   assign start       = (state_q == IDLE) && enable && ({head_x, head_y} != head_prev_q);

   always_comb begin
      seg_x = '0;
      seg_y = '0;
      for (int i = 0; i < SEGMENTS; i++) begin
         if (idx_q == 4'(i)) begin
            seg_x = snap_tx_q[7*i +: 7];
            seg_y = snap_ty_q[6*i +: 6];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      head_prev_d = head_prev_q;
      idx_d       = idx_q;
      hit_d       = hit_q;
      game_over_d = game_over_q;
      if (clear) begin
         game_over_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               head_prev_d = {head_x, head_y};
               hit_d       = 1'b0;
               state_d     = WALL;
            end
         end
         WALL: begin
            // Out-of-range includes the wrap-around values produced by moving past column/row 0.
            if ((snap_hx_q >= GRID_W_C) || (snap_hy_q >= GRID_H_C)) begin
               hit_d   = 1'b1;
               state_d = REPORT;
            end else if (snap_len_q == 4'd0) begin
               state_d = REPORT;
            end else begin
               idx_d   = 4'd0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if ((seg_x == snap_hx_q) && (seg_y == snap_hy_q)) begin
               hit_d   = 1'b1;
               state_d = REPORT;
            end else if (idx_q == snap_len_q - 4'd1) begin
               state_d = REPORT;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         REPORT: begin
            if (hit_q) begin
               game_over_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         head_prev_q <= HEAD_RST;
         idx_q       <= '0;
         hit_q       <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_prev_q <= head_prev_d;
         idx_q       <= idx_d;
         hit_q       <= hit_d;
         game_over_q <= game_over_d;
      end
   end

   // The check works only on this snapshot so mid-check bus activity cannot corrupt it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_hx_q  <= '0;
         snap_hy_q  <= '0;
         snap_tx_q  <= '0;
         snap_ty_q  <= '0;
         snap_len_q <= '0;
      end else if (start) begin
         snap_hx_q  <= head_x;
         snap_hy_q  <= head_y;
         snap_tx_q  <= tail_x;
         snap_ty_q  <= tail_y;
         snap_len_q <= len_clamped;
      end
   end

   assign busy      = (state_q == WALL) || (state_q == SCAN);
   assign collision = (state_q == REPORT) && hit_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_collision.sv
// tb/tb_snake_collision.sv - directed self-checking bench for snake_collision
module tb_snake_collision;

   logic         clk;
   logic         reset;
   logic [6:0]   head_x;
   logic [5:0]   head_y;
   logic [104:0] tail_x;
   logic [89:0]  tail_y;
   logic [3:0]   length;
   logic         enable;
   logic         clear;
   logic         busy;
   logic         collision;
   logic         game_over;

   int n_checks = 0;
   int n_fail   = 0;

   snake_collision dut (
      .clk       (clk),
      .reset     (reset),
      .head_x    (head_x),
      .head_y    (head_y),
      .tail_x    (tail_x),
      .tail_y    (tail_y),
      .length    (length),
      .enable    (enable),
      .clear     (clear),
      .busy      (busy),
      .collision (collision),
      .game_over (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_seg(input int i, input int x, input int y);
      tail_x[7*i +: 7] = 7'(x);
      tail_y[6*i +: 6] = 6'(y);
   endtask

   // Moves the head and watches 22 cycles; cycle 1 is the first cycle after the detecting edge.
   task automatic run_check(input int hx, input int hy,
                            output int busy_n, output int coll_n, output int coll_at);
      head_x  = 7'(hx);
      head_y  = 6'(hy);
      busy_n  = 0;
      coll_n  = 0;
      coll_at = -1;
      for (int c = 1; c <= 22; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) busy_n++;
         if (collision) begin
            coll_n++;
            coll_at = c;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int bad;
      reset  = 1'b0;
      head_x = 7'd32;
      head_y = 6'd24;
      tail_x = '0;
      tail_y = '0;
      length = 4'd0;
      enable = 1'b1;
      clear  = 1'b0;
      idle_cycles(3);
      n_checks++;
      if ({busy, collision, game_over} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 000", {busy, collision, game_over});
      end
      reset = 1'b1;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if ({busy, collision, game_over} !== 3'b000) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_release_quiet: %0d active cycles, expected 0", bad);
      end
   endtask

   task automatic test_tail_miss();
      int b, cn, ca;
      set_seg(0, 32, 24);
      set_seg(1, 31, 24);
      set_seg(2, 30, 24);
      length = 4'd3;
      run_check(33, 24, b, cn, ca);
      n_checks++;
      if (b !== 4) begin
         n_fail++;
         $display("FAIL miss_busy_cycles: got %0d expected 4", b);
      end
      n_checks++;
      if (cn !== 0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_no_collision: got coll=%0d go=%b expected 0/0", cn, game_over);
      end
   endtask

   task automatic test_tail_hit();
      int b, cn, ca;
      run_check(31, 24, b, cn, ca);
      n_checks++;
      if (b !== 3) begin
         n_fail++;
         $display("FAIL hit_busy_cycles: got %0d expected 3", b);
      end
      n_checks++;
      if (cn !== 1 || ca !== 4) begin
         n_fail++;
         $display("FAIL hit_pulse: got count=%0d at=%0d expected 1 at 4", cn, ca);
      end
      n_checks++;
      if (game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_game_over_sticky: got %b expected 1", game_over);
      end
      clear = 1'b1;
      idle_cycles(1);
      clear = 1'b0;
      n_checks++;
      if (game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_clear: got %b expected 0", game_over);
      end
   endtask

   task automatic test_walls();
      int b, cn, ca;
      int hx[3] = '{64, 127, 10};
      int hy[3] = '{24, 24, 48};
      for (int k = 0; k < 3; k++) begin
         run_check(hx[k], hy[k], b, cn, ca);
         n_checks++;
         if (b !== 1 || cn !== 1 || ca !== 2) begin
            n_fail++;
            $display("FAIL wall_%0d: got busy=%0d coll=%0d at=%0d expected 1/1/2", k, b, cn, ca);
         end
      end
      n_checks++;
      if (game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL wall_game_over: got %b expected 1", game_over);
      end
      clear = 1'b1;
      idle_cycles(1);
      clear = 1'b0;
   endtask

   task automatic test_length_bounds();
      int b, cn, ca;
      set_seg(0, 5, 5);
      length = 4'd0;
      run_check(5, 5, b, cn, ca);
      n_checks++;
      if (b !== 1 || cn !== 0) begin
         n_fail++;
         $display("FAIL len0: got busy=%0d coll=%0d expected 1/0", b, cn);
      end
      set_seg(0, 1, 1);
      set_seg(1, 2, 2);
      set_seg(2, 7, 7);
      length = 4'd2;
      run_check(7, 7, b, cn, ca);
      n_checks++;
      if (b !== 3 || cn !== 0) begin
         n_fail++;
         $display("FAIL beyond_length: got busy=%0d coll=%0d expected 3/0", b, cn);
      end
      for (int i = 0; i < 14; i++) set_seg(i, i + 20, 30);
      set_seg(14, 6, 6);
      length = 4'd15;
      run_check(6, 6, b, cn, ca);
      n_checks++;
      if (b !== 16 || cn !== 1 || ca !== 17) begin
         n_fail++;
         $display("FAIL len15_last: got busy=%0d coll=%0d at=%0d expected 16/1/17", b, cn, ca);
      end
   endtask

   task automatic test_enable();
      int b, cn, ca, bad;
      enable = 1'b0;
      head_x = 7'd8;
      head_y = 6'd8;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL enable_off: got %0d busy cycles expected 0", bad);
      end
      enable = 1'b1;
      run_check(8, 8, b, cn, ca);
      n_checks++;
      if (b !== 16 || cn !== 0) begin
         n_fail++;
         $display("FAIL enable_on: got busy=%0d coll=%0d expected 16/0", b, cn);
      end
      clear = 1'b1;
      idle_cycles(1);
      clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      int b, cn, ca;
      set_seg(0, 32, 24);
      set_seg(1, 31, 24);
      set_seg(2, 30, 24);
      length = 4'd3;
      head_x = 7'd40;
      head_y = 6'd10;
      b = 0;
      cn = 0;
      ca = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) b++;
         if (collision) begin
            cn++;
            ca = c;
         end
         if (c == 2) begin
            head_x = 7'd41;
            set_seg(1, 41, 10);
         end
         if (c == 3) begin
            head_x = 7'd31;
            head_y = 6'd24;
            set_seg(1, 31, 24);
         end
      end
      n_checks++;
      if (b !== 7) begin
         n_fail++;
         $display("FAIL b2b_busy: got %0d expected 7", b);
      end
      n_checks++;
      if (cn !== 1 || ca !== 10) begin
         n_fail++;
         $display("FAIL b2b_pulse: got count=%0d at=%0d expected 1 at 10", cn, ca);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      for (int i = 0; i < 15; i++) set_seg(i, i + 20, 40);
      length = 4'd15;
      head_x = 7'd9;
      head_y = 6'd9;
      idle_cycles(5);
      n_checks++;
      if (busy !== 1'b1 || game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: got busy=%b go=%b expected 1/1", busy, game_over);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, collision, game_over} !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset: got %b expected 000", {busy, collision, game_over});
      end
      head_x = 7'd32;
      head_y = 6'd24;
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy || collision) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL mid_after: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_clear_report();
      head_x = 7'd64;
      head_y = 6'd24;
      idle_cycles(2);
      n_checks++;
      if (collision !== 1'b1 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_report_pre: got coll=%b go=%b expected 1/0", collision, game_over);
      end
      clear = 1'b1;
      idle_cycles(1);
      clear = 1'b0;
      n_checks++;
      if (game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_hit_wins: got %b expected 1", game_over);
      end
   endtask

   initial begin
      test_reset();
      test_tail_miss();
      test_tail_hit();
      test_walls();
      test_length_bounds();
      test_enable();
      test_back_to_back();
      test_reset_mid();
      test_clear_report();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
